// File: rtl/btn_event_decoder.sv
// Per-button event decoder: turns a debounced level into press/release/click/double/long pulses.
// Optional auto-repeat while long-held is enabled by defining BTN_REPEAT_EN.
module btn_event_decoder #(
  parameter int unsigned CNT_W          = 27,
  parameter int unsigned LONG_CYCLES    = 50_000_000,
  parameter int unsigned DBL_GAP_CYCLES = 25_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic dbl_click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  // Elaboration-time range checks on the timing parameters
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("btn_event_decoder: CNT_W out of range");
  end
  if (LONG_CYCLES == 0 || 64'(LONG_CYCLES) >= (64'(1) << CNT_W)) begin : g_bad_long
    $error("btn_event_decoder: LONG_CYCLES out of range");
  end
  if (DBL_GAP_CYCLES == 0 || 64'(DBL_GAP_CYCLES) >= (64'(1) << CNT_W)) begin : g_bad_gap
    $error("btn_event_decoder: DBL_GAP_CYCLES out of range");
  end
  if (REPEAT_CYCLES == 0 || 64'(REPEAT_CYCLES) >= (64'(1) << CNT_W)) begin : g_bad_repeat
    $error("btn_event_decoder: REPEAT_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DBL_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_q;
  logic             press_q;
  logic             release_q;
  logic             click_q;
  logic             dbl_q;
  logic             long_q;
  logic             busy_q;
  logic             rise_c;
  logic             fall_c;
  logic [CNT_W-1:0] cnt_inc_c;

  assign rise_c    = btn_level & ~btn_q;
  assign fall_c    = ~btn_level & btn_q;
  // Timing counter saturates instead of wrapping
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef BTN_REPEAT_EN
  logic repeat_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dbl_q     <= 1'b0;
      long_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
    end else begin
      btn_q     <= btn_level;
      press_q   <= rise_c;
      release_q <= fall_c;
      click_q   <= 1'b0;
      dbl_q     <= 1'b0;
      long_q    <= 1'b0;
      cnt_q     <= cnt_inc_c;
`ifdef BTN_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
      // Edges always win over a counter terminal hit in the same cycle
      unique case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            state_q <= ST_PRESS1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_PRESS1: begin
          if (fall_c) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_TERM) begin
            state_q <= ST_LONG;
            cnt_q   <= '0;
            long_q  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (rise_c) begin
            state_q <= ST_PRESS2;
            cnt_q   <= '0;
          end else if (cnt_q == GAP_TERM) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            click_q <= 1'b1;
          end
        end
        ST_PRESS2: begin
          if (fall_c) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            dbl_q   <= 1'b1;
          end else if (cnt_q == LONG_TERM) begin
            state_q <= ST_LONG;
            cnt_q   <= '0;
            long_q  <= 1'b1;
          end
        end
        ST_LONG: begin
          if (fall_c) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
`ifdef BTN_REPEAT_EN
          else if (cnt_q == REP_TERM) begin
            cnt_q    <= '0;
            repeat_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign press_pulse     = press_q;
  assign release_pulse   = release_q;
  assign click_pulse     = click_q;
  assign dbl_click_pulse = dbl_q;
  assign long_pulse      = long_q;
  assign busy            = busy_q;
`ifdef BTN_REPEAT_EN
  assign repeat_pulse    = repeat_q;
`else
  assign repeat_pulse    = 1'b0;
`endif

endmodule
